// File: rtl/vx_socket_mem_arb_pkg.sv
`default_nettype none
// ============================================================================
// Module      : vx_socket_mem_arb_pkg
// Description : Shared types and width helpers for the socket memory arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
package vx_socket_mem_arb_pkg;

    typedef enum logic [1:0] {
        CLS_NONE   = 2'd0,
        CLS_LOW    = 2'd1,
        CLS_HIGH   = 2'd2,
        CLS_URGENT = 2'd3
    } arb_class_e;

    // Source-index width; a single input needs no index bits at all.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 0;
    endfunction

endpackage
`default_nettype wire

// File: rtl/vx_socket_mem_arb_aging_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : vx_socket_mem_arb_aging_arbiter
// Description : Class-based round-robin arbiter with anti-starvation aging.
// Revision    : 1.0 - initial release
// ============================================================================
module vx_socket_mem_arb_aging_arbiter
    import vx_socket_mem_arb_pkg::*;
#(
    parameter int NUM_REQS  = 2,
    parameter int PRIO_MASK = 1,
    parameter int AGE_LIMIT = 16,
    localparam int IDX_WS   = (NUM_REQS > 1) ? $clog2(NUM_REQS) : 1
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [NUM_REQS-1:0] req_valid,
    input  logic [NUM_REQS-1:0] req_eligible,
    input  logic                accept,
    output logic [NUM_REQS-1:0] grant,
    output logic [IDX_WS-1:0]   grant_idx
);

    localparam int AGE_W = $clog2(AGE_LIMIT + 1);
    localparam logic [NUM_REQS-1:0] PRIO = NUM_REQS'(PRIO_MASK);

    logic [AGE_W-1:0]    age [NUM_REQS];
    logic [IDX_WS-1:0]   rr_ptr;
    logic [NUM_REQS-1:0] urgent, high, low, cand;
    logic                found;
    arb_class_e          cls;

    always_comb begin
        urgent = '0;
        high   = '0;
        low    = '0;
        for (int i = 0; i < NUM_REQS; i++) begin
            if (req_eligible[i]) begin
                if (PRIO[i])
                    high[i] = 1'b1;
                else if (age[i] == AGE_W'(AGE_LIMIT))
                    urgent[i] = 1'b1;
                else
                    low[i] = 1'b1;
            end
        end
    end

    always_comb begin
        if (|urgent)    cls = CLS_URGENT;
        else if (|high) cls = CLS_HIGH;
        else if (|low)  cls = CLS_LOW;
        else            cls = CLS_NONE;
    end

    // Round-robin: first candidate at or above the pointer, else wrap to the lowest.
    always_comb begin
        case (cls)
            CLS_URGENT: cand = urgent;
            CLS_HIGH:   cand = high;
            CLS_LOW:    cand = low;
            default:    cand = '0;
        endcase
        grant     = '0;
        grant_idx = '0;
        found     = 1'b0;
        for (int i = 0; i < NUM_REQS; i++) begin
            if (!found && cand[i] && (IDX_WS'(i) >= rr_ptr)) begin
                found     = 1'b1;
                grant[i]  = 1'b1;
                grant_idx = IDX_WS'(i);
            end
        end
        for (int i = 0; i < NUM_REQS; i++) begin
            if (!found && cand[i]) begin
                found     = 1'b1;
                grant[i]  = 1'b1;
                grant_idx = IDX_WS'(i);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rr_ptr <= '0;
        end else if (accept) begin
            rr_ptr <= (grant_idx == IDX_WS'(NUM_REQS - 1)) ? '0 : grant_idx + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        for (int i = 0; i < NUM_REQS; i++) begin
            if (reset || PRIO[i] || !req_valid[i] || (accept && grant[i]))
                age[i] <= '0;
            else if (req_eligible[i] && (age[i] != AGE_W'(AGE_LIMIT)))
                age[i] <= age[i] + 1'b1;
        end
    end

endmodule
`default_nettype wire

// File: rtl/vx_socket_mem_arb.sv
`default_nettype none
// ============================================================================
// Module      : vx_socket_mem_arb
// Description : Merges L1 request streams onto one memory port, routes responses.
// Revision    : 1.0 - initial release
// ============================================================================
module vx_socket_mem_arb
    import vx_socket_mem_arb_pkg::*;
#(
    parameter int NUM_INPUTS  = 2,
    parameter int DATA_SIZE   = 64,
    parameter int ADDR_WIDTH  = 26,
    parameter int TAG_WIDTH   = 8,
    parameter int PRIO_MASK   = 1,
    parameter int AGE_LIMIT   = 16,
    parameter int MAX_PENDING = 8,
    localparam int IDX_W      = idx_width(NUM_INPUTS),
    localparam int OUT_TAG_W  = TAG_WIDTH + IDX_W
) (
    input  logic                                   clk,
    input  logic                                   reset,
    input  logic [NUM_INPUTS-1:0]                  in_req_valid,
    output logic [NUM_INPUTS-1:0]                  in_req_ready,
    input  logic [NUM_INPUTS-1:0]                  in_req_rw,
    input  logic [NUM_INPUTS-1:0][ADDR_WIDTH-1:0]  in_req_addr,
    input  logic [NUM_INPUTS-1:0][8*DATA_SIZE-1:0] in_req_data,
    input  logic [NUM_INPUTS-1:0][DATA_SIZE-1:0]   in_req_byteen,
    input  logic [NUM_INPUTS-1:0][TAG_WIDTH-1:0]   in_req_tag,
    output logic [NUM_INPUTS-1:0]                  in_rsp_valid,
    input  logic [NUM_INPUTS-1:0]                  in_rsp_ready,
    output logic [8*DATA_SIZE-1:0]                 in_rsp_data,
    output logic [TAG_WIDTH-1:0]                   in_rsp_tag,
    output logic                                   out_req_valid,
    input  logic                                   out_req_ready,
    output logic                                   out_req_rw,
    output logic [ADDR_WIDTH-1:0]                  out_req_addr,
    output logic [8*DATA_SIZE-1:0]                 out_req_data,
    output logic [DATA_SIZE-1:0]                   out_req_byteen,
    output logic [OUT_TAG_W-1:0]                   out_req_tag,
    input  logic                                   out_rsp_valid,
    output logic                                   out_rsp_ready,
    input  logic [8*DATA_SIZE-1:0]                 out_rsp_data,
    input  logic [OUT_TAG_W-1:0]                   out_rsp_tag,
    output logic                                   busy
);

    localparam int DATA_W = 8 * DATA_SIZE;
    localparam int IDX_WS = (IDX_W > 0) ? IDX_W : 1;
    localparam int PEND_W = $clog2(MAX_PENDING + 1);
    localparam int PL_W   = 1 + ADDR_WIDTH + DATA_W + DATA_SIZE + OUT_TAG_W;

    logic [NUM_INPUTS-1:0] eligible, grant, pend_inc, pend_dec;
    logic [IDX_WS-1:0]     grant_idx, rsp_src;
    logic [PEND_W-1:0]     pending      [NUM_INPUTS];
    logic [PEND_W-1:0]     pending_next [NUM_INPUTS];
    logic                  any_pend_next, src_pend_zero, rsp_fire;
    logic                  buf_ready, push, pop, buf_wr, buf_rd;
    logic [1:0]            buf_cnt, cnt_next;
    logic [PL_W-1:0]       buf_mem [2];
    logic                  sel_rw;
    logic [ADDR_WIDTH-1:0] sel_addr;
    logic [DATA_W-1:0]     sel_data;
    logic [DATA_SIZE-1:0]  sel_byteen;
    logic [TAG_WIDTH-1:0]  sel_tag;
    logic [OUT_TAG_W-1:0]  sel_out_tag;

    // Writes never allocate a response slot, so only reads are throttled.
    always_comb begin
        for (int i = 0; i < NUM_INPUTS; i++)
            eligible[i] = in_req_valid[i] && (in_req_rw[i] || (pending[i] < PEND_W'(MAX_PENDING)));
    end

    vx_socket_mem_arb_aging_arbiter #(
        .NUM_REQS  (NUM_INPUTS),
        .PRIO_MASK (PRIO_MASK),
        .AGE_LIMIT (AGE_LIMIT)
    ) u_arbiter (
        .clk          (clk),
        .reset        (reset),
        .req_valid    (in_req_valid),
        .req_eligible (eligible),
        .accept       (push),
        .grant        (grant),
        .grant_idx    (grant_idx)
    );

    assign buf_ready    = (buf_cnt != 2'd2);
    assign push         = (|grant) && buf_ready;
    assign in_req_ready = grant & {NUM_INPUTS{buf_ready}};

    always_comb begin
        sel_rw     = 1'b0;
        sel_addr   = '0;
        sel_data   = '0;
        sel_byteen = '0;
        sel_tag    = '0;
        for (int i = 0; i < NUM_INPUTS; i++) begin
            if (grant[i]) begin
                sel_rw     = in_req_rw[i];
                sel_addr   = in_req_addr[i];
                sel_data   = in_req_data[i];
                sel_byteen = in_req_byteen[i];
                sel_tag    = in_req_tag[i];
            end
        end
    end

    if (IDX_W > 0) begin : g_tag_idx
        assign sel_out_tag = {sel_tag, grant_idx};
        assign rsp_src     = out_rsp_tag[IDX_W-1:0];
        assign in_rsp_tag  = out_rsp_tag[OUT_TAG_W-1:IDX_W];
    end else begin : g_tag_pass
        assign sel_out_tag = sel_tag;
        assign rsp_src     = '0;
        assign in_rsp_tag  = out_rsp_tag;
    end

    // An out-of-range source is drained (ready=1) rather than allowed to stall the port.
    always_comb begin
        in_rsp_valid  = '0;
        out_rsp_ready = 1'b1;
        src_pend_zero = 1'b1;
        for (int i = 0; i < NUM_INPUTS; i++) begin
            if (rsp_src == IDX_WS'(i)) begin
                in_rsp_valid[i] = out_rsp_valid;
                out_rsp_ready   = in_rsp_ready[i];
                src_pend_zero   = (pending[i] == '0);
            end
        end
    end

    assign in_rsp_data = out_rsp_data;
    assign rsp_fire    = out_rsp_valid && out_rsp_ready;

    always_comb begin
        any_pend_next = 1'b0;
        for (int i = 0; i < NUM_INPUTS; i++) begin
            pend_inc[i]     = push && grant[i] && !in_req_rw[i];
            pend_dec[i]     = rsp_fire && in_rsp_valid[i] && (pending[i] != '0);
            pending_next[i] = pending[i];
            if (pend_inc[i] && !pend_dec[i])
                pending_next[i] = pending[i] + 1'b1;
            else if (pend_dec[i] && !pend_inc[i])
                pending_next[i] = pending[i] - 1'b1;
            any_pend_next = any_pend_next || (pending_next[i] != '0);
        end
    end

    assign out_req_valid = (buf_cnt != 2'd0);
    assign pop           = out_req_valid && out_req_ready;

    always_comb begin
        cnt_next = buf_cnt;
        if (push && !pop)
            cnt_next = buf_cnt + 2'd1;
        else if (pop && !push)
            cnt_next = buf_cnt - 2'd1;
    end

    always_ff @(posedge clk) begin
        if (push)
            buf_mem[buf_wr] <= {sel_rw, sel_addr, sel_data, sel_byteen, sel_out_tag};
    end

    assign {out_req_rw, out_req_addr, out_req_data, out_req_byteen, out_req_tag} = buf_mem[buf_rd];

    always_ff @(posedge clk) begin
        if (reset) begin
            buf_cnt <= 2'd0;
            buf_wr  <= 1'b0;
            buf_rd  <= 1'b0;
            busy    <= 1'b0;
            for (int i = 0; i < NUM_INPUTS; i++)
                pending[i] <= '0;
        end else begin
            buf_cnt <= cnt_next;
            if (push) buf_wr <= ~buf_wr;
            if (pop)  buf_rd <= ~buf_rd;
            busy    <= any_pend_next || (cnt_next != 2'd0);
            for (int i = 0; i < NUM_INPUTS; i++)
                pending[i] <= pending_next[i];
        end
    end

    // A response must always match an outstanding read of a real input.
    always_ff @(posedge clk) begin
        if (!reset && rsp_fire)
            assert (!src_pend_zero);
    end

endmodule
`default_nettype wire

// File: tb/tb_vx_socket_mem_arb.sv
`default_nettype none
// ============================================================================
// Module      : tb_vx_socket_mem_arb
// Description : Directed self-checking bench for the socket memory arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_vx_socket_mem_arb;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    // Two-input instance: input 0 high priority, AGE_LIMIT 4
    logic             a_reset;
    logic [1:0]       a_req_valid, a_req_ready, a_req_rw;
    logic [1:0][25:0] a_req_addr;
    logic [1:0][31:0] a_req_data;
    logic [1:0][3:0]  a_req_byteen;
    logic [1:0][7:0]  a_req_tag;
    logic [1:0]       a_rsp_valid, a_rsp_ready;
    logic [31:0]      a_rsp_data;
    logic [7:0]       a_rsp_tag;
    logic             a_oreq_valid, a_oreq_ready, a_oreq_rw;
    logic [25:0]      a_oreq_addr;
    logic [31:0]      a_oreq_data;
    logic [3:0]       a_oreq_byteen;
    logic [8:0]       a_oreq_tag;
    logic             a_orsp_valid, a_orsp_ready;
    logic [31:0]      a_orsp_data;
    logic [8:0]       a_orsp_tag;
    logic             a_busy;

    // Four-input instance: all low priority
    logic             b_reset;
    logic [3:0]       b_req_valid, b_req_ready, b_req_rw;
    logic [3:0][25:0] b_req_addr;
    logic [3:0][31:0] b_req_data;
    logic [3:0][3:0]  b_req_byteen;
    logic [3:0][7:0]  b_req_tag;
    logic [3:0]       b_rsp_valid, b_rsp_ready;
    logic [31:0]      b_rsp_data;
    logic [7:0]       b_rsp_tag;
    logic             b_oreq_valid, b_oreq_ready, b_oreq_rw;
    logic [25:0]      b_oreq_addr;
    logic [31:0]      b_oreq_data;
    logic [3:0]       b_oreq_byteen;
    logic [9:0]       b_oreq_tag;
    logic             b_orsp_valid, b_orsp_ready;
    logic [31:0]      b_orsp_data;
    logic [9:0]       b_orsp_tag;
    logic             b_busy;

    vx_socket_mem_arb #(
        .NUM_INPUTS(2), .DATA_SIZE(4), .ADDR_WIDTH(26), .TAG_WIDTH(8),
        .PRIO_MASK(1), .AGE_LIMIT(4), .MAX_PENDING(8)
    ) dut2 (
        .clk(clk), .reset(a_reset),
        .in_req_valid(a_req_valid), .in_req_ready(a_req_ready), .in_req_rw(a_req_rw),
        .in_req_addr(a_req_addr), .in_req_data(a_req_data), .in_req_byteen(a_req_byteen),
        .in_req_tag(a_req_tag), .in_rsp_valid(a_rsp_valid), .in_rsp_ready(a_rsp_ready),
        .in_rsp_data(a_rsp_data), .in_rsp_tag(a_rsp_tag),
        .out_req_valid(a_oreq_valid), .out_req_ready(a_oreq_ready), .out_req_rw(a_oreq_rw),
        .out_req_addr(a_oreq_addr), .out_req_data(a_oreq_data), .out_req_byteen(a_oreq_byteen),
        .out_req_tag(a_oreq_tag), .out_rsp_valid(a_orsp_valid), .out_rsp_ready(a_orsp_ready),
        .out_rsp_data(a_orsp_data), .out_rsp_tag(a_orsp_tag), .busy(a_busy)
    );

    vx_socket_mem_arb #(
        .NUM_INPUTS(4), .DATA_SIZE(4), .ADDR_WIDTH(26), .TAG_WIDTH(8),
        .PRIO_MASK(0), .AGE_LIMIT(16), .MAX_PENDING(8)
    ) dut4 (
        .clk(clk), .reset(b_reset),
        .in_req_valid(b_req_valid), .in_req_ready(b_req_ready), .in_req_rw(b_req_rw),
        .in_req_addr(b_req_addr), .in_req_data(b_req_data), .in_req_byteen(b_req_byteen),
        .in_req_tag(b_req_tag), .in_rsp_valid(b_rsp_valid), .in_rsp_ready(b_rsp_ready),
        .in_rsp_data(b_rsp_data), .in_rsp_tag(b_rsp_tag),
        .out_req_valid(b_oreq_valid), .out_req_ready(b_oreq_ready), .out_req_rw(b_oreq_rw),
        .out_req_addr(b_oreq_addr), .out_req_data(b_oreq_data), .out_req_byteen(b_oreq_byteen),
        .out_req_tag(b_oreq_tag), .out_rsp_valid(b_orsp_valid), .out_rsp_ready(b_orsp_ready),
        .out_rsp_data(b_orsp_data), .out_rsp_tag(b_orsp_tag), .busy(b_busy)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic advance();
        @(posedge clk);
        #1;
    endtask

    logic [1:0] age_seq [10];
    logic [3:0] rr_seq  [5];
    logic [9:0] rr_tag  [5];

    initial begin
        age_seq = '{2'b01, 2'b01, 2'b01, 2'b01, 2'b10, 2'b01, 2'b01, 2'b01, 2'b01, 2'b10};
        rr_seq  = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
        rr_tag  = '{10'h000, 10'h100, 10'h105, 10'h10A, 10'h10F};

        a_reset = 1'b1; b_reset = 1'b1;
        a_req_valid = '0; a_req_rw = '0; a_req_data = '0; a_req_byteen = '0;
        a_req_addr = '{26'h200, 26'h100};
        a_req_tag  = '{8'h22, 8'h11};
        a_rsp_ready = 2'b11; a_oreq_ready = 1'b1;
        a_orsp_valid = 1'b0; a_orsp_data = 32'hCAFEF00D; a_orsp_tag = '0;
        b_req_valid = '0; b_req_rw = '0; b_req_data = '0; b_req_byteen = '0;
        b_req_addr = '0;
        b_req_tag  = '{8'h43, 8'h42, 8'h41, 8'h40};
        b_rsp_ready = '1; b_oreq_ready = 1'b1;
        b_orsp_valid = 1'b0; b_orsp_data = '0; b_orsp_tag = '0;

        advance();
        advance();

        // Reset state and combinational response routing while held in reset
        @(negedge clk);
        chk("rst_out_req_valid", a_oreq_valid, 0);
        chk("rst_busy", a_busy, 0);
        chk("rst_in_rsp_valid_idle", a_rsp_valid, 2'b00);
        a_orsp_valid = 1'b1; a_orsp_tag = 9'h0B5;
        #1;
        chk("rsp_route_valid", a_rsp_valid, 2'b10);
        chk("rsp_route_tag", a_rsp_tag, 8'h5A);
        chk("rsp_route_data", a_rsp_data, 32'hCAFEF00D);
        chk("rsp_ready_pass", a_orsp_ready, 1);
        a_rsp_ready = 2'b01;
        #1;
        chk("rsp_ready_block", a_orsp_ready, 0);
        a_orsp_tag = 9'h066;
        #1;
        chk("rsp_route_src0", a_rsp_valid, 2'b01);
        a_orsp_valid = 1'b0; a_rsp_ready = 2'b11;
        advance();
        a_reset = 1'b0; b_reset = 1'b0;

        // Aging: input 1 (low priority) wins once every 5 accepts
        a_req_rw = 2'b11; a_req_valid = 2'b11;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            chk($sformatf("age_grant%0d", k), a_req_ready, age_seq[k]);
            if (k == 0) chk("first_latency", a_oreq_valid, 0);
            if (k == 5) begin
                chk("age_fwd_tag", a_oreq_tag, 9'h045);
                chk("age_fwd_addr", a_oreq_addr, 26'h200);
                chk("age_fwd_rw", a_oreq_rw, 1);
            end
            if (k == 6) chk("stream_busy", a_busy, 1);
            advance();
        end
        a_req_valid = 2'b00;
        advance(); advance(); advance();
        @(negedge clk);
        chk("write_drain_valid", a_oreq_valid, 0);
        chk("write_drain_busy", a_busy, 0);
        advance();

        // Outstanding-read limit on input 0
        a_req_rw = 2'b00; a_req_valid = 2'b01;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            chk($sformatf("pend_ok%0d", k), a_req_ready, 2'b01);
            advance();
        end
        a_req_rw = 2'b10; a_req_valid = 2'b11;
        @(negedge clk);
        chk("pend_stall_other_served", a_req_ready, 2'b10);
        advance();
        a_req_valid = 2'b01; a_orsp_valid = 1'b1; a_orsp_tag = 9'h022;
        @(negedge clk);
        chk("pend_rsp_valid", a_rsp_valid, 2'b01);
        chk("pend_rsp_tag", a_rsp_tag, 8'h11);
        chk("pend_still_stalled", a_req_ready, 2'b00);
        advance();
        a_orsp_valid = 1'b0;
        @(negedge clk);
        chk("pend_reopen", a_req_ready, 2'b01);
        advance();
        a_req_valid = 2'b00;
        @(negedge clk);
        chk("pend_busy", a_busy, 1);
        a_orsp_valid = 1'b1;
        for (int k = 0; k < 8; k++) advance();
        a_orsp_valid = 1'b0;
        advance(); advance();
        @(negedge clk);
        chk("pend_drain_busy", a_busy, 0);
        advance();

        // Reset with two buffered requests and three outstanding reads
        a_oreq_ready = 1'b0; a_req_rw = 2'b00; a_req_valid = 2'b01;
        advance(); advance();
        a_oreq_ready = 1'b1;
        @(negedge clk);
        chk("buf_full_ready", a_req_ready, 2'b00);
        advance();
        a_oreq_ready = 1'b0;
        advance();
        @(negedge clk);
        chk("pre_rst_valid", a_oreq_valid, 1);
        chk("pre_rst_busy", a_busy, 1);
        a_reset = 1'b1; a_req_valid = 2'b00;
        advance();
        a_reset = 1'b0;
        @(negedge clk);
        chk("post_rst_valid", a_oreq_valid, 0);
        chk("post_rst_busy", a_busy, 0);
        a_oreq_ready = 1'b1; a_req_valid = 2'b01;
        for (int k = 0; k < 7; k++) advance();
        @(negedge clk);
        chk("post_rst_read8", a_req_ready, 2'b01);
        advance();
        @(negedge clk);
        chk("post_rst_read9", a_req_ready, 2'b00);
        a_req_valid = 2'b00;
        advance();

        // Four-input plain round-robin
        b_req_rw = 4'hF; b_req_valid = 4'hF;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            chk($sformatf("rr_grant%0d", k), b_req_ready, rr_seq[k]);
            chk($sformatf("rr_out_valid%0d", k), b_oreq_valid, (k == 0) ? 0 : 1);
            if (k > 0) chk($sformatf("rr_out_tag%0d", k), b_oreq_tag, rr_tag[k]);
            advance();
        end
        b_req_valid = 4'h0;
        advance();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
